// File: rtl/demux_pkg.sv
// Shared constants and FSM state type for the demux dispatcher.
package demux_pkg;

    localparam int NCH        = 4;
    localparam int CH_W       = 2;
    localparam int DROP_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Small first-word-fall-through FIFO: head word is visible while not empty.
module sync_fifo #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       count_q;
    logic              push_ok;
    logic              pop_ok;

    // A full FIFO refuses pushes even when a pop happens in the same cycle.
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem[rd_ptr_q];

    // Storage write; contents need no reset since occupancy guards reads.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/demux_dispatcher.sv
// Feeds a 4-way demux from a small FIFO, choosing channels round-robin or
// fixed, honouring per-channel ready and dropping heads that stall too long.
module demux_dispatcher
    import demux_pkg::*;
#(
    parameter int DATA_W  = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    input  logic                     mode,
    input  logic [CH_W-1:0]          cfg_ch,
    input  logic [NCH-1:0]           ch_ready,
    output logic [CH_W-1:0]          select,
    output logic                     enable,
    output logic [DATA_W-1:0]        data,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [DROP_CNT_W-1:0]    drop_cnt
);

    // Counter only needs to reach TIMEOUT-1; keep at least one bit.
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_W-1:0]     head;
    logic                  pop;

    logic                  found;
    logic [CH_W-1:0]       chosen;

    // state_q holds the decision taken last cycle; SEND means a word was issued.
    state_e                state_q, state_d;
    logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic [CH_W-1:0]       select_q, select_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Pick the eligible channel: cfg_ch in fixed mode, else first ready from rr_ptr.
    always_comb begin
        found  = 1'b0;
        chosen = rr_ptr_q;
        if (mode) begin
            found  = ch_ready[cfg_ch];
            chosen = cfg_ch;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (!found && ch_ready[rr_ptr_q + CH_W'(i)]) begin
                    found  = 1'b1;
                    chosen = rr_ptr_q + CH_W'(i);
                end
            end
        end
    end

    // Per-cycle decision: issue, wait (possibly timing out into a drop) or idle.
    always_comb begin
        state_d    = IDLE;
        pop        = 1'b0;
        wait_d     = '0;
        rr_ptr_d   = rr_ptr_q;
        select_d   = select_q;
        data_d     = '0;
        drop_cnt_d = drop_cnt_q;
        if (!fifo_empty) begin
            if (found) begin
                state_d  = SEND;
                pop      = 1'b1;
                select_d = chosen;
                data_d   = head;
                if (!mode) rr_ptr_d = chosen + 1'b1;
            end else begin
                state_d = WAIT;
                if ((TIMEOUT != 0) && (wait_q == WAIT_LAST)) begin
                    pop = 1'b1;
                    if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
        end
    end

    // Registered decision state, arbiter pointer, timeout counter and outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            wait_q     <= '0;
            select_q   <= '0;
            data_q     <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            wait_q     <= wait_d;
            select_q   <= select_d;
            data_q     <= data_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign in_ready = !fifo_full;
    assign enable   = (state_q == SEND);
    assign select   = select_q;
    assign data     = data_q;
    assign drop_cnt = drop_cnt_q;

endmodule
